uart_rx_monitor: RTL and testbench



---
 rtl/uart_mon_pkg.sv | 7 +
 rtl/uart_mon_matcher.sv | 37 +++
 rtl/uart_rx_monitor.sv | 130 +++++++++++++
 tb/tb_uart_rx_monitor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_mon_pkg.sv
// uart_mon_pkg: receiver state encoding and the ASCII end-of-test markers.
package uart_mon_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
  localparam int MARKER_LEN = 11;
  localparam logic [0:MARKER_LEN-1][7:0] PASS_STR = "TEST_PASSED";
  localparam logic [0:MARKER_LEN-1][7:0] FAIL_STR = "TEST_FAILED";
endpackage

// File: rtl/uart_mon_matcher.sv
// uart_mon_matcher: streaming KMP matcher for one marker string, sticky hit flag.
module uart_mon_matcher
  import uart_mon_pkg::*;
#(
  parameter logic [0:MARKER_LEN-1][7:0] PATTERN = PASS_STR
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] byte_i,
  input  logic       strobe_i,
  output logic       hit_o
);
  logic [3:0] idx_q, idx_d, nxt;
  logic       hit_q, hit_d;
  // The only self-overlap of the markers is the 'T' at position 3.
  always_comb begin
    nxt = (byte_i == PATTERN[idx_q]) ? idx_q + 4'd1 :
          (idx_q == 4'd4 && byte_i == PATTERN[1]) ? 4'd2 :
          (byte_i == PATTERN[0]) ? 4'd1 : 4'd0;
    idx_d = idx_q;
    hit_d = hit_q;
    if (strobe_i) begin
      idx_d = (nxt == 4'(MARKER_LEN)) ? 4'd0 : nxt;
      hit_d = hit_q | (nxt == 4'(MARKER_LEN));
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      hit_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      hit_q <= hit_d;
    end
  end
  assign hit_o = hit_q;
endmodule

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 receiver with byte FIFO, error flags and hardware
// detection of the TEST_PASSED / TEST_FAILED markers.
module uart_rx_monitor
  import uart_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 289,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic       frame_err_o,
  output logic       overflow_o,
  output logic       pass_o,
  output logic       fail_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q;
  logic [2:0]    boot_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          frame_err_q, frame_err_d, overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          rxs, expired, good, empty, full, push, pop;

  assign rxs     = sync_q[1];
  assign expired = cnt_q == '0;

  // boot_q[2] stays low until the synchroniser carries real line samples,
  // so a line already low after reset goes to BREAK instead of START.
  always_comb begin
    state_d     = state_q;
    cnt_d       = expired ? cnt_q : cnt_q - CW'(1);
    bit_d       = bit_q;
    data_d      = data_q;
    good        = 1'b0;
    frame_err_d = frame_err_q;
    case (state_q)
      IDLE: if (!rxs) begin
        state_d = boot_q[2] ? START : BREAK;
        cnt_d   = HALF;
      end
      START: if (expired) begin
        state_d = rxs ? IDLE : DATA;
        cnt_d   = FULL;
        bit_d   = '0;
      end
      DATA: if (expired) begin
        data_d[bit_q] = rxs;
        bit_d         = bit_q + 3'd1;
        cnt_d         = FULL;
        state_d       = (bit_q == 3'd7) ? STOP : DATA;
      end
      STOP: if (expired) begin
        good        = rxs;
        frame_err_d = frame_err_q | !rxs;
        state_d     = rxs ? IDLE : BREAK;
      end
      BREAK: state_d = rxs ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
  end

  assign empty      = wr_q == rd_q;
  assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop        = !empty && byte_ready_i;
  assign push       = good && (!full || pop);
  assign overflow_d = overflow_q | (good && full && !pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      boot_q      <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[0], rx_i};
      boot_q      <= {boot_q[1:0], 1'b1};
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= data_q;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (pop) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  assign byte_o       = mem_q[rd_q[AW-1:0]];
  assign byte_valid_o = !empty;
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;

  uart_mon_matcher #(.PATTERN(PASS_STR)) u_pass (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .byte_i  (data_q),
    .strobe_i(good),
    .hit_o   (pass_o)
  );

  uart_mon_matcher #(.PATTERN(FAIL_STR)) u_fail (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .byte_i  (data_q),
    .strobe_i(good),
    .hit_o   (fail_o)
  );
endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed scenarios for the UART RX monitor at 16 clocks per bit.
module tb_uart_rx_monitor;
  import uart_mon_pkg::*;
  localparam int CPB = 16;
  logic       clk = 1'b0, rst_ni = 1'b0, rx_i = 1'b1, byte_ready_i = 1'b1;
  logic [7:0] byte_o;
  logic       byte_valid_o, frame_err_o, overflow_o, pass_o, fail_o;
  int         total = 0, bad = 0, cyc = 0;
  logic [7:0] got_q[$];
  int         got_cyc[$];

  uart_rx_monitor #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Record every accepted byte and the cycle it was offered.
  always @(negedge clk) if (byte_valid_o && byte_ready_i) begin
    got_q.push_back(byte_o);
    got_cyc.push_back(cyc);
  end

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 byte_ready_i = r;
    @(negedge clk);
  endtask

  task automatic clear_log();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = (stop_low == 0);
    repeat (CPB * ((stop_low == 0) ? 1 : stop_low)) @(negedge clk);
    rx_i = 1'b1;
    repeat (CPB * 2) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({byte_o, byte_valid_o, frame_err_o, overflow_o, pass_o, fail_o} !== 13'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {byte_o, byte_valid_o, frame_err_o, overflow_o, pass_o, fail_o});
    end
    rst_ni = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (dut.state_q !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, IDLE); end
  endtask

  task automatic test_single();
    int c0;
    clear_log();
    c0 = cyc;
    send_frame(8'h55, 0);
    total++;
    if (got_q.size() !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", got_q.size()); end
    total++;
    if (got_q[0] !== 8'h55) begin bad++; $display("FAIL single_data got=%h want=55", got_q[0]); end
    // two synchroniser cycles plus the start-edge-to-valid latency
    total++;
    if (got_cyc[0] - c0 !== 2 + CPB / 2 + 9 * CPB + 1) begin
      bad++;
      $display("FAIL single_latency got=%0d want=%0d", got_cyc[0] - c0, 2 + CPB / 2 + 9 * CPB + 1);
    end
    total++;
    if ({frame_err_o, overflow_o} !== 2'b00) begin bad++; $display("FAIL single_flags got=%b want=00", {frame_err_o, overflow_o}); end
  endtask

  task automatic test_glitch();
    clear_log();
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    total++;
    if (got_q.size() !== 0) begin bad++; $display("FAIL glitch_count got=%0d want=0", got_q.size()); end
    total++;
    if (frame_err_o !== 1'b0) begin bad++; $display("FAIL glitch_ferr got=%b want=0", frame_err_o); end
    total++;
    if (dut.state_q !== IDLE) begin bad++; $display("FAIL glitch_state got=%0d want=%0d", dut.state_q, IDLE); end
    send_frame(8'hC3, 0);
    total++;
    if (got_q.size() !== 1 || got_q[0] !== 8'hC3) begin bad++; $display("FAIL glitch_next got=%h n=%0d want=c3", got_q[0], got_q.size()); end
  endtask

  task automatic test_frame_err();
    clear_log();
    send_frame(8'hA5, 2);
    total++;
    if (frame_err_o !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b want=1", frame_err_o); end
    total++;
    if (got_q.size() !== 0) begin bad++; $display("FAIL ferr_count got=%0d want=0", got_q.size()); end
    send_frame(8'h3C, 0);
    total++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h3C) begin bad++; $display("FAIL ferr_next got=%h n=%0d want=3c", got_q[0], got_q.size()); end
  endtask

  task automatic test_overflow();
    set_ready(1'b0);
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
    total++;
    if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow_o); end
    total++;
    if ({byte_valid_o, byte_o} !== 9'h101) begin bad++; $display("FAIL ovf_head got=%h want=101", {byte_valid_o, byte_o}); end
    clear_log();
    set_ready(1'b1);
    repeat (8) @(negedge clk);
    total++;
    if (got_q.size() !== 4) begin bad++; $display("FAIL ovf_count got=%0d want=4", got_q.size()); end
    total++;
    if ({got_q[0], got_q[1], got_q[2], got_q[3]} !== 32'h01020304) begin
      bad++;
      $display("FAIL ovf_order got=%h want=01020304", {got_q[0], got_q[1], got_q[2], got_q[3]});
    end
    total++;
    if (byte_valid_o !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%b want=0", byte_valid_o); end
  endtask

  task automatic test_markers();
    clear_log();
    send_str("xTESTEST_FAILE");
    total++;
    if (fail_o !== 1'b0) begin bad++; $display("FAIL mark_fail_early got=%b want=0", fail_o); end
    send_frame("D", 0);
    total++;
    if ({pass_o, fail_o} !== 2'b01) begin bad++; $display("FAIL mark_fail got=%b want=01", {pass_o, fail_o}); end
    send_frame(8'h0A, 0);
    send_str("TEST_PASSE");
    total++;
    if (pass_o !== 1'b0) begin bad++; $display("FAIL mark_pass_early got=%b want=0", pass_o); end
    send_frame("D", 0);
    total++;
    if ({pass_o, fail_o} !== 2'b11) begin bad++; $display("FAIL mark_both got=%b want=11", {pass_o, fail_o}); end
    total++;
    if (got_q.size() !== 27) begin bad++; $display("FAIL mark_count got=%0d want=27", got_q.size()); end
  endtask

  task automatic test_reset_mid();
    set_ready(1'b0);
    send_frame(8'h11, 0);
    total++;
    if ({byte_valid_o, byte_o} !== 9'h111) begin bad++; $display("FAIL rmid_held got=%h want=111", {byte_valid_o, byte_o}); end
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    rx_i = 1'b0;
    repeat (8) @(negedge clk);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({byte_o, byte_valid_o, frame_err_o, overflow_o, pass_o, fail_o} !== 13'h0) begin
      bad++;
      $display("FAIL rmid_outputs got=%h want=0", {byte_o, byte_valid_o, frame_err_o, overflow_o, pass_o, fail_o});
    end
    rst_ni = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (dut.state_q !== BREAK) begin bad++; $display("FAIL rmid_break got=%0d want=%0d", dut.state_q, BREAK); end
    repeat (10) @(negedge clk);
    rx_i = 1'b1;
    repeat (40) @(negedge clk);
    total++;
    if ({byte_valid_o, frame_err_o} !== 2'b00) begin bad++; $display("FAIL rmid_quiet got=%b want=00", {byte_valid_o, frame_err_o}); end
    clear_log();
    set_ready(1'b1);
    send_frame(8'h7E, 0);
    total++;
    if (got_q.size() !== 1 || got_q[0] !== 8'h7E) begin bad++; $display("FAIL rmid_next got=%h n=%0d want=7e", got_q[0], got_q.size()); end
    total++;
    if (frame_err_o !== 1'b0) begin bad++; $display("FAIL rmid_ferr got=%b want=0", frame_err_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_markers();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
